fft_stage_ctrl: RTL

Sequencer for an in-place radix-2 decimation-in-time FFT over a single-port-per-side working memory. On `start`, it walks all log2(N) stages and issues one butterfly per accepted handshake: operand addresses `addr_a`/`addr_b` plus a twiddle index into the ROM of `twiddle_t` values. It tracks outstanding butterflies and holds off each new stage until the previous stage's write-backs have landed. It sits between the top-level FFT control and the butterfly datapath, and is the only source of memory addresses during a transform.

---
 rtl/fft_pkg.sv | 40 ++++
 rtl/fft_addr_gen.sv | 29 ++
 rtl/fft_stage_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT types and helpers: controller state encoding and the radix-2 DIT
// butterfly address map used by the stage sequencer.
package fft_pkg;

  parameter int unsigned FFT_LOG2N = 4;
  localparam int unsigned FFT_MAX_LOG2N = 12;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } fft_ctrl_state_t;

  typedef struct packed {
    logic [FFT_MAX_LOG2N-1:0] addr_a;
    logic [FFT_MAX_LOG2N-1:0] addr_b;
    logic [FFT_MAX_LOG2N-2:0] tw_idx;
  } fft_bf_addr_t;

  // Butterfly k of stage s: pairs are half = 2^s apart, groups are 2*half wide.
  function automatic fft_bf_addr_t fft_bf_addr(int unsigned log2n, int unsigned s,
                                               int unsigned k);
    fft_bf_addr_t r;
    int unsigned  half;
    int unsigned  j;
    int unsigned  g;
    int unsigned  a;
    half     = 32'd1 << s;
    j        = k & (half - 32'd1);
    g        = k >> s;
    // j < half, so OR-ing j into the group base is an add.
    a        = ((g << 1) << s) | j;
    r.addr_a = FFT_MAX_LOG2N'(a);
    r.addr_b = FFT_MAX_LOG2N'(a + half);
    r.tw_idx = (FFT_MAX_LOG2N - 1)'(j << (log2n - 32'd1 - s));
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational (stage, butterfly index) to operand/twiddle address map,
// sliced to the configured transform size.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N = FFT_LOG2N,
  localparam int unsigned SW = $clog2(LOG2N)
) (
  input  logic [SW-1:0]    s_i,
  input  logic [LOG2N-2:0] k_i,
  output logic [LOG2N-1:0] addr_a_o,
  output logic [LOG2N-1:0] addr_b_o,
  output logic [LOG2N-2:0] tw_idx_o
);

  fft_bf_addr_t bf;
  logic         unused_bf;

  always_comb begin
    bf       = fft_bf_addr(LOG2N, 32'(s_i), 32'(k_i));
    addr_a_o = bf.addr_a[LOG2N-1:0];
    addr_b_o = bf.addr_b[LOG2N-1:0];
    tw_idx_o = bf.tw_idx[LOG2N-2:0];
  end

  // Upper bits beyond LOG2N are always zero for legal (s, k).
  assign unused_bf = ^bf;

endmodule

// File: rtl/fft_stage_ctrl.sv
// In-place radix-2 DIT FFT stage sequencer: issues butterflies stage by stage and
// drains outstanding write-backs before starting each new stage.
module fft_stage_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N = FFT_LOG2N,
  localparam int unsigned SW = $clog2(LOG2N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             bf_valid,
  input  logic             bf_ready,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic [SW-1:0]    stage,
  input  logic             wb_valid,
  output logic             err
);

  localparam int unsigned KW = LOG2N - 1;
  localparam int unsigned CW = LOG2N;
  localparam logic [KW-1:0] KLast = '1;
  localparam logic [SW-1:0] SLast = SW'(LOG2N - 1);

  fft_ctrl_state_t  state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [SW-1:0]    s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bf_valid_q, bf_valid_d;
  logic [LOG2N-1:0] addr_a_q, addr_a_d;
  logic [LOG2N-1:0] addr_b_q, addr_b_d;
  logic [LOG2N-2:0] tw_idx_q, tw_idx_d;
  logic [SW-1:0]    stage_q, stage_d;

  logic             issue;
  logic [LOG2N-1:0] gen_addr_a;
  logic [LOG2N-1:0] gen_addr_b;
  logic [LOG2N-2:0] gen_tw_idx;

  // Addresses are generated for the next (s, k) so the registered outputs
  // always describe the butterfly currently being presented.
  fft_addr_gen #(
    .LOG2N (LOG2N)
  ) u_addr_gen (
    .s_i      (s_d),
    .k_i      (k_d),
    .addr_a_o (gen_addr_a),
    .addr_b_o (gen_addr_b),
    .tw_idx_o (gen_tw_idx)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    issue   = bf_valid_q && bf_ready;

    if (wb_valid && (cnt_q == '0)) begin
      err_d = 1'b1;
    end
    if (issue && !wb_valid) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!issue && wb_valid && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StIssue;
          s_d     = '0;
          k_d     = '0;
        end
      end
      StIssue: begin
        if (issue) begin
          if (k_q == KLast) begin
            state_d = StWait;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      StWait: begin
        if (cnt_d == '0) begin
          if (s_q == SLast) begin
            state_d = StDone;
          end else begin
            state_d = StIssue;
            s_d     = s_q + SW'(1);
            k_d     = '0;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        s_d     = '0;
        k_d     = '0;
      end
    endcase

    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
    bf_valid_d = (state_d == StIssue);
    stage_d    = s_d;
    addr_a_d   = bf_valid_d ? gen_addr_a : '0;
    addr_b_d   = bf_valid_d ? gen_addr_b : '0;
    tw_idx_d   = bf_valid_d ? gen_tw_idx : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      k_q        <= '0;
      s_q        <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bf_valid_q <= 1'b0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      tw_idx_q   <= '0;
      stage_q    <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      s_q        <= s_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bf_valid_q <= bf_valid_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      tw_idx_q   <= tw_idx_d;
      stage_q    <= stage_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bf_valid = bf_valid_q;
  assign addr_a   = addr_a_q;
  assign addr_b   = addr_b_q;
  assign tw_idx   = tw_idx_q;
  assign stage    = stage_q;
  assign err      = err_q;

endmodule
